// File: rtl/cond_execute_unit.sv
// Execute-stage control register, NZCV flags and condition gating.
// Decode controls are registered into E, then side effects are qualified by the condition check.
module cond_execute_unit #(
  parameter int         ALUCTRL_W = 4,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 PCSrcD,
  input  logic                 RegWriteD,
  input  logic                 MemToRegD,
  input  logic                 MemWriteD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic                 NoWriteD,
  input  logic                 FlagWriteD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [3:0]           CondD,
  input  logic [3:0]           ALUFlagsE,
  output logic                 PCSrcE,
  output logic                 RegWriteE,
  output logic                 MemToRegE,
  output logic                 MemWriteE,
  output logic                 BranchTakenE,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 CondExE,
  output logic [3:0]           FlagsE
);

  localparam logic [3:0] COND_AL = 4'b1110;

  logic                 pcsrc_r;
  logic                 regwrite_r;
  logic                 memtoreg_r;
  logic                 memwrite_r;
  logic                 branch_r;
  logic                 alusrc_r;
  logic                 nowrite_r;
  logic                 flagwrite_r;
  logic [ALUCTRL_W-1:0] alucontrol_r;
  logic [3:0]           cond_r;
  logic [3:0]           flags_r;
  logic                 cond_ex;
  logic                 flag_we;
  logic                 n, z, c, v;

  // Reset and flush both load a bubble: no side-effect bits, condition AL.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      pcsrc_r      <= 1'b0;
      regwrite_r   <= 1'b0;
      memtoreg_r   <= 1'b0;
      memwrite_r   <= 1'b0;
      branch_r     <= 1'b0;
      alusrc_r     <= 1'b0;
      nowrite_r    <= 1'b0;
      flagwrite_r  <= 1'b0;
      alucontrol_r <= '0;
      cond_r       <= COND_AL;
    end else if (!StallE) begin
      pcsrc_r      <= PCSrcD;
      regwrite_r   <= RegWriteD;
      memtoreg_r   <= MemToRegD;
      memwrite_r   <= MemWriteD;
      branch_r     <= BranchD;
      alusrc_r     <= ALUSrcD;
      nowrite_r    <= NoWriteD;
      flagwrite_r  <= FlagWriteD;
      alucontrol_r <= ALUControlD;
      cond_r       <= CondD;
    end
  end

  // A flush does not cancel the instruction already in E, so it may still write flags.
  assign flag_we = flagwrite_r & cond_ex & ~StallE;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= FLAGS_RST;
    end else if (flag_we) begin
      flags_r <= ALUFlagsE;
    end
  end

  assign {n, z, c, v} = flags_r;

  always_comb begin
    cond_ex = 1'b0;
    case (cond_r)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign PCSrcE       = pcsrc_r & cond_ex;
  assign RegWriteE    = regwrite_r & cond_ex & ~nowrite_r;
  assign MemWriteE    = memwrite_r & cond_ex;
  assign BranchTakenE = branch_r & cond_ex;
  assign MemToRegE    = memtoreg_r;
  assign ALUSrcE      = alusrc_r;
  assign ALUControlE  = alucontrol_r;
  assign CondExE      = cond_ex;
  assign FlagsE       = flags_r;

endmodule

// File: doc/cond_execute_unit.md
Name: cond_execute_unit

Overview:
Execute-stage control block directly downstream of the decode-stage control unit. It registers the decode control bundle into the E stage (the D→E pipeline register for control only) and holds the architectural NZCV flags register. It evaluates each instruction's 4-bit condition field against the flags and gates the side-effecting controls (PC redirect, register write, memory write, branch). It also supports hazard-unit stall/flush.

Parameters:
ALUCTRL_W, 4, width of the ALU control field.
FLAGS_RST, 4'b0000, reset value of the NZCV flags register.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
StallE  in  1  hold E-stage control register and flags.
FlushE  in  1  replace E-stage contents with a bubble.
PCSrcD  in  1  decode: PC written by this instruction.
RegWriteD  in  1  decode: register-file write.
MemToRegD  in  1  decode: writeback selects memory data.
MemWriteD  in  1  decode: data-memory write.
BranchD  in  1  decode: branch instruction.
ALUSrcD  in  1  decode: ALU B operand is immediate.
NoWriteD  in  1  decode: compare; suppress register write.
FlagWriteD  in  1  decode: instruction updates NZCV.
ALUControlD  in  ALUCTRL_W  decode ALU operation.
CondD  in  4  condition field, instr[31:28].
ALUFlagsE  in  4  {N,Z,C,V} from the E-stage ALU, current cycle.
PCSrcE  out  1  gated PC redirect.
RegWriteE  out  1  gated register write.
MemToRegE  out  1  registered pass-through.
MemWriteE  out  1  gated memory write.
BranchTakenE  out  1  gated branch taken.
ALUSrcE  out  1  registered pass-through.
ALUControlE  out  ALUCTRL_W  registered pass-through.
CondExE  out  1  condition passed for the instruction now in E.
FlagsE  out  4  current architectural {N,Z,C,V}.

Behaviour:
- E control register update priority, per posedge: reset > FlushE > StallE > capture the D inputs.
- Reset and flush both clear every registered control bit to 0 and set CondE to 4'b1110 (AL), producing a bubble with no side effects.
- Reset additionally sets the flags to FLAGS_RST.
- All outputs are 0 after reset, except:
  - CondExE = 1, because the bubble's CondE is AL.
  - FlagsE = FLAGS_RST.
- Latency: decode inputs appear on the E outputs one cycle after capture.
- Condition evaluation is combinational from registered CondE and registered flags:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - MI 0100: N
  - PL 0101: !N
  - VS 0110: V
  - VC 0111: !V
  - HI 1000: C&!Z
  - LS 1001: !C|Z
  - GE 1010: N==V
  - LT 1011: N!=V
  - GT 1100: !Z&(N==V)
  - LE 1101: Z|(N!=V)
  - AL 1110: 1
  - 1111: 0 (reserved; never executes)
- Gating:
  - PCSrcE = PCSrcE_r & CondExE
  - RegWriteE = RegWriteE_r & CondExE & !NoWriteE_r
  - MemWriteE = MemWriteE_r & CondExE
  - BranchTakenE = BranchE_r & CondExE
- Flags update: at posedge, flags <= ALUFlagsE only when FlagWriteE_r & CondExE & !StallE & !reset. Otherwise the flags hold.
- A FlushE in the same cycle does not block a flag write by the instruction currently in E; that instruction has already executed.
- Flag visibility: the next instruction in E sees the updated flags. There is no same-cycle bypass of ALUFlagsE into the condition logic.
- StallE and FlushE together: flush wins for the control register; the flags do not update (stall holds).
- A reset asserted mid-stall or mid-flush overrides both.

Test Plan:
- Reset for 2 cycles, then release with D inputs at 0 → all gated outputs 0, CondExE=1, FlagsE=0000.
- Drive CMP (FlagWriteD=1, NoWriteD=1, RegWriteD=1, CondD=1110) with ALUFlagsE=0100 → RegWriteE=0 in E; FlagsE=0100 one cycle later.
- With flags Z=1, issue a BEQ (BranchD=1, CondD=0000) → BranchTakenE=1. Then issue a BNE (CondD=0001) → BranchTakenE=0.
- With flags N=1, V=0: STR with CondD=1011 (LT) → MemWriteE=1; CondD=1010 (GE) → MemWriteE=0.
- Hold StallE=1 for 3 cycles while changing the D inputs → E outputs and FlagsE unchanged. Then pulse FlushE=1 together with StallE=1 → next cycle is a bubble (all gated outputs 0).
- Apply CondD=1111 with RegWriteD=1 and FlagWriteD=1 → RegWriteE=0 and flags unchanged. Then assert reset during a valid ADD in E → outputs return to their reset values next edge.
